// File: rtl/rx_cfg_sequencer.sv
// RX chain configuration sequencer: reset, single-cycle rate load, settle, then enable.
// Commands are accepted only in IDLE and RUN; illegal start rates only set the sticky error.
module rx_cfg_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RATE_MIN      = 4,
  parameter int RATE_MAX      = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_start_i,
  input  logic [15:0] cmd_rate_i,
  output logic        rx_rst_n_o,
  output logic [15:0] rx_rate_axis_tdata_o,
  output logic        rx_rate_axis_tvalid_o,
  output logic        rx_en_o,
  output logic        running_o,
  output logic        err_o
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [15:0] RATE_LO = 16'(RATE_MIN);
  localparam logic [15:0] RATE_HI = 16'(RATE_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      rate_q, rate_d;
  logic             err_q, err_d;
  logic             rx_rst_n_q, rx_rst_n_d;
  logic             tvalid_q, tvalid_d;
  logic [15:0]      tdata_q, tdata_d;
  logic             run_q, run_d;
  logic             ready_q, ready_d;
  logic             accept_s;
  logic             rate_ok_s;

  assign accept_s  = cmd_valid_i & ready_q;
  assign rate_ok_s = (cmd_rate_i >= RATE_LO) && (cmd_rate_i <= RATE_HI);

  // State, counter, latched rate and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rate_q     <= 16'd0;
      err_q      <= 1'b0;
      rx_rst_n_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= 16'd0;
      run_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rate_q     <= rate_d;
      err_q      <= err_d;
      rx_rst_n_q <= rx_rst_n_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      run_q      <= run_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state, counter and command handling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept_s) begin
          if (cmd_start_i && rate_ok_s) begin
            state_d = S_RESET;
            cnt_d   = RST_LOAD;
            rate_d  = cmd_rate_i;
            err_d   = 1'b0;
          end else if (cmd_start_i) begin
            err_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LOAD: begin
        // Zero settle time goes straight from the rate strobe to RUN
        if (SETTLE_CYCLES == 0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values decoded from the upcoming state so they register in step with it
  always_comb begin
    rx_rst_n_d = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
    tvalid_d   = (state_d == S_LOAD);
    run_d      = (state_d == S_RUN);
    ready_d    = (state_d == S_IDLE) || (state_d == S_RUN);
    if (state_d == S_LOAD) begin
      tdata_d = rate_q;
    end else begin
      tdata_d = tdata_q;
    end
  end

  assign cmd_ready_o           = ready_q;
  assign rx_rst_n_o            = rx_rst_n_q;
  assign rx_rate_axis_tdata_o  = tdata_q;
  assign rx_rate_axis_tvalid_o = tvalid_q;
  assign rx_en_o               = run_q;
  assign running_o             = run_q;
  assign err_o                 = err_q;

endmodule
